// File: rtl/spram_arb_pkg.sv
// Shared types for the two-client single-port RAM arbiter.
package spram_arb_pkg;

   localparam int unsigned NUM_CLIENTS  = 2;
   localparam int unsigned READ_LATENCY = 2;

   typedef logic [0:0] client_id_t;

   typedef struct packed {
      logic       valid;
      client_id_t client;
   } tag_t;

endpackage

// File: rtl/spram_arb_rr.sv
// Two-way round-robin picker; while a lock is held only the lock owner may be granted.
module spram_arb_rr
   import spram_arb_pkg::*;
(
   input  logic [NUM_CLIENTS-1:0] req,
   input  client_id_t             last,
   input  logic                   lock_active,
   input  client_id_t             lock_owner,
   output logic [NUM_CLIENTS-1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (lock_active) begin
         gnt[lock_owner] = req[lock_owner];
      end else if (req[0] && req[1]) begin
         gnt[~last] = 1'b1;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/singleportram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle read) between two clients.
// Define SPRAM_ARB_LOCK_EN to add c0_lock/c1_lock for atomic read-modify-write.
module singleportram_arbiter
   import spram_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c0_req,
   input  logic             c0_we,
   input  logic [31:0]      c0_addr,
   input  logic [WIDTH-1:0] c0_din,
`ifdef SPRAM_ARB_LOCK_EN
   input  logic             c0_lock,
`endif
   output logic             c0_gnt,
   output logic             c0_rvalid,
   output logic [WIDTH-1:0] c0_dout,
   input  logic             c1_req,
   input  logic             c1_we,
   input  logic [31:0]      c1_addr,
   input  logic [WIDTH-1:0] c1_din,
`ifdef SPRAM_ARB_LOCK_EN
   input  logic             c1_lock,
`endif
   output logic             c1_gnt,
   output logic             c1_rvalid,
   output logic [WIDTH-1:0] c1_dout,
   output logic [31:0]      ram_address,
   output logic [WIDTH-1:0] ram_din,
   output logic             ram_we,
   output logic             ram_oe,
   input  logic [WIDTH-1:0] ram_dout
);

   // The RAM owns address truncation; only sanity-check the width here.
   if (DEPTH < 1 || DEPTH > 32) begin : g_depth_check
      $error("singleportram_arbiter: DEPTH must be in 1..32");
   end

   logic [NUM_CLIENTS-1:0] req;
   logic [NUM_CLIENTS-1:0] rr_gnt;
   logic [NUM_CLIENTS-1:0] gnt;
   logic                   accept;
   logic                   sel_we;
   logic                   lock_active;
   client_id_t             lock_owner;
   client_id_t             last_q;
   client_id_t             sel;
   tag_t                   tag1_q;
   tag_t                   tag2_q;
   logic [31:0]            ram_address_q;
   logic [WIDTH-1:0]       ram_din_q;
   logic                   ram_we_q;
   logic                   ram_oe_q;
   logic [WIDTH-1:0]       c0_dout_q;
   logic [WIDTH-1:0]       c1_dout_q;

   assign req = {c1_req, c0_req};

   spram_arb_rr u_rr (
      .req         (req),
      .last        (last_q),
      .lock_active (lock_active),
      .lock_owner  (lock_owner),
      .gnt         (rr_gnt)
   );

   assign gnt    = reset ? rr_gnt : '0;
   assign c0_gnt = gnt[0];
   assign c1_gnt = gnt[1];
   assign accept = |gnt;
   assign sel    = client_id_t'(gnt[1]);
   assign sel_we = sel[0] ? c1_we : c0_we;

`ifdef SPRAM_ARB_LOCK_EN
   logic       lock_q;
   client_id_t lock_owner_q;
   logic       sel_lock;

   assign sel_lock = sel[0] ? c1_lock : c0_lock;

   // Each accepted request from the granted client re-decides the lock.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lock_q       <= 1'b0;
         lock_owner_q <= '0;
      end else if (accept) begin
         lock_q       <= sel_lock;
         lock_owner_q <= sel;
      end
   end

   assign lock_active = lock_q;
   assign lock_owner  = lock_owner_q;
`else
   assign lock_active = 1'b0;
   assign lock_owner  = '0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         ram_address_q <= '0;
         ram_din_q     <= '0;
         ram_we_q      <= 1'b0;
         ram_oe_q      <= 1'b0;
         tag1_q        <= '0;
         tag2_q        <= '0;
         c0_dout_q     <= '0;
         c1_dout_q     <= '0;
         last_q        <= client_id_t'(1'b1);
      end else begin
         ram_we_q <= 1'b0;
         ram_oe_q <= 1'b0;
         tag1_q   <= '0;
         if (accept) begin
            ram_address_q <= sel[0] ? c1_addr : c0_addr;
            ram_din_q     <= sel[0] ? c1_din : c0_din;
            ram_we_q      <= sel_we;
            ram_oe_q      <= 1'b1;
            tag1_q.valid  <= ~sel_we;
            tag1_q.client <= sel;
            last_q        <= sel;
         end
         tag2_q <= tag1_q;
         if (c0_rvalid) c0_dout_q <= ram_dout;
         if (c1_rvalid) c1_dout_q <= ram_dout;
      end
   end

   // Stage-2 tag lines up with the RAM's registered output; dout then holds it.
   assign c0_rvalid = tag2_q.valid && (tag2_q.client == 1'b0);
   assign c1_rvalid = tag2_q.valid && (tag2_q.client == 1'b1);
   assign c0_dout   = c0_rvalid ? ram_dout : c0_dout_q;
   assign c1_dout   = c1_rvalid ? ram_dout : c1_dout_q;

   assign ram_address = ram_address_q;
   assign ram_din     = ram_din_q;
   assign ram_we      = ram_we_q;
   assign ram_oe      = ram_oe_q;

endmodule

// File: tb/tb_singleportram_arbiter.sv
// Bench for singleportram_arbiter with a synchronous-read RAM model and read-data scoreboard.
// Lock rows change their expected grants when SPRAM_ARB_LOCK_EN is defined.
module tb_singleportram_arbiter;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             reset;
   logic             c0_req, c0_we, c1_req, c1_we;
   logic [31:0]      c0_addr, c1_addr;
   logic [WIDTH-1:0] c0_din, c1_din;
   logic             c0_lock, c1_lock;
   logic             c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
   logic [WIDTH-1:0] c0_dout, c1_dout;
   logic [31:0]      ram_address;
   logic [WIDTH-1:0] ram_din, ram_dout;
   logic             ram_we, ram_oe;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   typedef struct {
      logic        r0, w0, k0;
      logic [31:0] a0, d0;
      logic        r1, w1, k1;
      logic [31:0] a1, d1;
      logic        g0, g1;
   } vec_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          n_checks;
   int          n_fail;
   int          cyc;
   logic        mon_en;
   logic        preload;
   logic [31:0] shadow [0:1023];
   logic [31:0] mem [0:1023];
   logic [31:0] last_d0, last_d1, last_addr;

   singleportram_arbiter #(
      .WIDTH (WIDTH),
      .DEPTH (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .c0_req      (c0_req),
      .c0_we       (c0_we),
      .c0_addr     (c0_addr),
      .c0_din      (c0_din),
`ifdef SPRAM_ARB_LOCK_EN
      .c0_lock     (c0_lock),
`endif
      .c0_gnt      (c0_gnt),
      .c0_rvalid   (c0_rvalid),
      .c0_dout     (c0_dout),
      .c1_req      (c1_req),
      .c1_we       (c1_we),
      .c1_addr     (c1_addr),
      .c1_din      (c1_din),
`ifdef SPRAM_ARB_LOCK_EN
      .c1_lock     (c1_lock),
`endif
      .c1_gnt      (c1_gnt),
      .c1_rvalid   (c1_rvalid),
      .c1_dout     (c1_dout),
      .ram_address (ram_address),
      .ram_din     (ram_din),
      .ram_we      (ram_we),
      .ram_oe      (ram_oe),
      .ram_dout    (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM, registered read output, address truncated to 10 bits.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         mem[1] <= 32'h11;
         mem[2] <= 32'h22;
      end else if (ram_oe === 1'b1) begin
         if (ram_we) mem[ram_address[9:0]] <= ram_din;
         else        ram_dout <= mem[ram_address[9:0]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Read-data scoreboard: every rvalid must match the oldest expected read of that client.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (c0_rvalid) begin
            if (q0.size() == 0) check("c0_rvalid_unexpected", c0_rvalid, 0);
            else begin
               e = q0.pop_front();
               check("c0_dout", c0_dout, e.data);
               check("c0_rvalid_cycle", cyc, e.due);
               last_d0 = e.data;
            end
         end else if (q0.size() != 0 && q0[0].due < cyc) begin
            void'(q0.pop_front());
            check("c0_rvalid_missing", c0_rvalid, 1);
         end
         if (c1_rvalid) begin
            if (q1.size() == 0) check("c1_rvalid_unexpected", c1_rvalid, 0);
            else begin
               e = q1.pop_front();
               check("c1_dout", c1_dout, e.data);
               check("c1_rvalid_cycle", cyc, e.due);
               last_d1 = e.data;
            end
         end else if (q1.size() != 0 && q1[0].due < cyc) begin
            void'(q1.pop_front());
            check("c1_rvalid_missing", c1_rvalid, 1);
         end
      end
   end

   function automatic vec_t row(input logic r0, w0, k0, input logic [31:0] a0, d0,
                                input logic r1, w1, k1, input logic [31:0] a1, d1,
                                input logic g0, g1);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.k0 = k0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.k1 = k1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      logic        acc, we;
      logic [31:0] a, d;
      c0_req = v.r0; c0_we = v.w0; c0_addr = v.a0; c0_din = v.d0; c0_lock = v.k0;
      c1_req = v.r1; c1_we = v.w1; c1_addr = v.a1; c1_din = v.d1; c1_lock = v.k1;
      #1;
      check("c0_gnt", c0_gnt, v.g0);
      check("c1_gnt", c1_gnt, v.g1);
      acc = v.g0 | v.g1;
      we  = v.g1 ? v.w1 : v.w0;
      a   = v.g1 ? v.a1 : v.a0;
      d   = v.g1 ? v.d1 : v.d0;
      if (acc) begin
         if (we)        shadow[a[9:0]] = d;
         else if (v.g1) q1.push_back('{data: shadow[a[9:0]], due: cyc + 2});
         else           q0.push_back('{data: shadow[a[9:0]], due: cyc + 2});
      end
      @(posedge clk); #1;
      check("ram_oe", ram_oe, acc);
      check("ram_we", ram_we, acc & we);
      if (acc) last_addr = a;
      check("ram_address", ram_address, last_addr);
      if (acc && we) check("ram_din", ram_din, d);
   endtask

   initial begin
      vec_t vecs[$];
      vec_t idle;
      n_checks = 0; n_fail = 0; cyc = 0; mon_en = 1'b0; preload = 1'b1;
      reset = 1'b0;
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = '0; c0_din = '0; c0_lock = 1'b0;
      c1_req = 1'b1; c1_we = 1'b0; c1_addr = '0; c1_din = '0; c1_lock = 1'b0;
      for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
      shadow[1] = 32'h11;
      shadow[2] = 32'h22;

      @(posedge clk); #1;
      preload = 1'b0;
      check("reset_c0_gnt", c0_gnt, 0);
      check("reset_c1_gnt", c1_gnt, 0);
      @(posedge clk); #1;
      reset = 1'b1; c0_req = 1'b0; c1_req = 1'b0;
      last_d0 = '0; last_d1 = '0; last_addr = '0;
      mon_en = 1'b1;
      check("reset_ram_we", ram_we, 0);
      check("reset_ram_oe", ram_oe, 0);
      check("reset_ram_address", ram_address, 0);
      check("reset_ram_din", ram_din, 0);
      check("reset_c0_rvalid", c0_rvalid, 0);
      check("reset_c1_rvalid", c1_rvalid, 0);
      check("reset_c0_dout", c0_dout, 0);
      check("reset_c1_dout", c1_dout, 0);

      idle = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      //          r0 w0 k0 a0 d0            r1 w1 k1 a1 d1       g0 g1
      vecs.push_back(row(1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(idle);
      vecs.push_back(row(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1));
      for (int i = 0; i < 4; i++)
         vecs.push_back(row(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, (i % 2) == 0, (i % 2) == 1));
      vecs.push_back(row(0, 0, 0, 0, 0, 1, 1, 0, 7, 32'hA5, 0, 1));
      vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 1));
      vecs.push_back(row(1, 1, 0, 9, 32'h1234, 1, 0, 0, 9, 0, 1, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, 0, 9, 0, 0, 1));
      vecs.push_back(row(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(row(1, 0, 0, 1, 0, 1, 0, 1, 3, 0, 0, 1));
`ifdef SPRAM_ARB_LOCK_EN
      vecs.push_back(row(1, 0, 0, 1, 0, 1, 1, 0, 3, 32'h77, 0, 1));
`else
      vecs.push_back(row(1, 0, 0, 1, 0, 1, 1, 0, 3, 32'h77, 1, 0));
`endif
      vecs.push_back(row(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(idle);

      foreach (vecs[i]) apply(vecs[i]);

      check("c0_dout_hold", c0_dout, last_d0);
      check("c1_dout_hold", c1_dout, last_d1);

      // Read accepted, then reset before its data returns: the read must vanish.
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = 5; c0_lock = 1'b0; c1_lock = 1'b0;
      #1;
      check("mr_c0_gnt", c0_gnt, 1);
      @(posedge clk); #1;
      reset = 1'b0; c0_req = 1'b0; c1_req = 1'b1; c1_we = 1'b0; c1_addr = 2;
      #1;
      check("mr_c1_gnt_in_reset", c1_gnt, 0);
      @(posedge clk); #1;
      reset = 1'b1; c1_req = 1'b0;
      last_d0 = '0; last_d1 = '0; last_addr = '0;
      check("mr_ram_we", ram_we, 0);
      check("mr_ram_oe", ram_oe, 0);
      check("mr_c0_dout", c0_dout, 0);
      repeat (3) @(posedge clk);
      #1;

      apply(row(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 1, 0));
      apply(row(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 0, 1));
      for (int i = 0; i < 3; i++) apply(idle);

      check("c0_queue_drained", q0.size(), 0);
      check("c1_queue_drained", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/singleportram_arbiter.md
Name: singleportram_arbiter

Overview:
- Two-client arbiter that shares one singleportram instance (1-cycle read latency, port-B style interface) between two requesters.
- Accepts one access per cycle, using round-robin between clients.
- Registers the winning command onto the RAM port.
- Routes read data back to the issuing client with a valid pulse.
- Sits between two datapath engines and the RAM; the RAM's WIDTH, DEPTH and WORDS stay owned by the RAM instance.

Parameters:
WIDTH, 32, data width; must match the attached RAM
DEPTH, 10, address bits used by the RAM; the arbiter passes all 32 address bits and the RAM truncates them

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
c0_req  in  1  client 0 access request; fields below held stable while req=1 and gnt=0
c0_we  in  1  1 = write, 0 = read
c0_addr  in  32  word address
c0_din  in  WIDTH  write data
c0_gnt  out  1  request accepted this cycle (combinational from req and arbitration state)
c0_rvalid  out  1  one-cycle pulse: c0_dout holds read data
c0_dout  out  WIDTH  read data
c1_req, c1_we, c1_addr, c1_din, c1_gnt, c1_rvalid, c1_dout: same as client 0
ram_address  out  32  to RAM address_b
ram_din  out  WIDTH  to RAM din_b
ram_we  out  1  to RAM we_b
ram_oe  out  1  to RAM oe_b; 1 for every issued command
ram_dout  in  WIDTH  from RAM dout_b

Behaviour:
- Reset (reset=0 at posedge) values:
  - ram_we=0, ram_oe=0, ram_address=0, ram_din=0.
  - Both rvalid=0; both dout=0.
  - Round-robin pointer last=1, so client 0 wins the first contest.
- gnt is forced to 0 while reset=0.
- Arbitration (combinational):
  - Only one client requests: that client is granted.
  - Both request: grant the client != last.
  - Neither requests: no grant.
  - At most one gnt is high in any cycle.
- Acceptance: a request is accepted at the posedge where req=1 and gnt=1. On that edge:
  - last <= granted client.
  - The issue stage loads ram_address, ram_din, ram_we, and sets ram_oe=1.
  - A tag {valid = is_read, client} is loaded.
- Idle cycles: when no request is accepted, ram_we=0 and ram_oe=0 at the next edge. ram_address and ram_din hold their previous values.
- Read pipeline:
  - Stage 1: the tag is registered alongside the RAM command.
  - Stage 2: on the next edge, the tag moves on, and the tagged client's dout <= ram_dout and its rvalid=1 for one cycle.
  - Read latency: acceptance edge T, rvalid high in cycle T+2 (i.e. after 2 posedges).
- Fully pipelined: back-to-back accepts every cycle, with no bubbles.
- dout holds its last value when rvalid=0.
- Writes produce no rvalid.
- Read-after-write: a write accepted at T followed by a read of the same address accepted at T+1 returns the new data (the RAM updates mem at T+1, the read samples it at T+2).
- Clients unmasked: a client may keep req=1 continuously; with the other client idle, it is granted every cycle.
- Reset mid-operation:
  - All in-flight tags are cleared, so no rvalid is produced for pre-reset reads.
  - The RAM contents are not touched (ram_we forced to 0).

Optional Feature:
- Macro: SPRAM_ARB_LOCK_EN.
- With the macro defined:
  - Adds ports c0_lock and c1_lock (in, 1 bit), sampled with req.
  - An accepted request with lock=1 sets a lock owner. Only the owner can be granted until it has an accepted request with lock=0, which releases the lock on that edge.
  - The other client's gnt stays 0 throughout; this is used for atomic read-modify-write.
  - Reset clears the lock.
- Without the macro: the lock ports are absent and arbitration is pure round-robin.

Decomposition:
- Package spram_arb_pkg holds:
  - NUM_CLIENTS=2
  - READ_LATENCY=2
  - client_id_t (1-bit client index)
  - tag struct {valid, client_id_t}
- Sub-module spram_arb_rr: 2-way round-robin picker (inputs: req[1:0], last, lock state; outputs: gnt[1:0]).
- The pipeline registers stay in the top level.

Test Plan:
- Reset, then c0 writes addr 5 = 0xDEADBEEF:
  - c0_gnt=1 in the same cycle.
  - Next cycle: ram_we=1, ram_address=5.
  - No rvalid pulse on either client.
- c0 reads addr 5, accepted at T → c0_rvalid=1 at T+2 with c0_dout=0xDEADBEEF; c1_rvalid stays 0.
- c0 and c1 both hold req=1 (reads of addrs 1 and 2, preloaded with 0x11 and 0x22) for 4 cycles:
  - Grants alternate c0, c1, c0, c1.
  - rvalids alternate with data 0x11, 0x22, ...
- c1 writes addr 7 = 0xA5 at T, c1 reads addr 7 at T+1 → c1_rvalid at T+3 with 0xA5.
- c0 read accepted, then reset=0 for one cycle at T+1 → no rvalid at T+2 or later; ram_we=0; the first contest after reset goes to c0.
- With SPRAM_ARB_LOCK_EN: c1 issues a locked read, then an unlocked write to addr 3, while c0 requests continuously:
  - c0_gnt=0 until the c1 write is accepted.
  - c0 is granted on the following cycle.
